// File: rtl/diffeq_driver.sv
// diffeq_driver: iteration controller that drives the diffeq step core through
// its ap_start/ap_done handshake. It integrates x and u locally and collects
// y from the core, looping while x < a or until MAX_ITER iterations have run.
module diffeq_driver #(
    parameter int unsigned MAX_ITER = 1000
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    input  logic [31:0] x0,
    input  logic [31:0] dx,
    input  logic [31:0] u0,
    input  logic [31:0] y0,
    input  logic [31:0] a,
    output logic [31:0] ap_return,
    output logic [31:0] x_out,
    output logic [31:0] u_out,
    output logic [31:0] y_out,
    output logic [15:0] iter_count,
    output logic        step_start,
    output logic [31:0] step_x,
    output logic [31:0] step_dx,
    output logic [31:0] step_u,
    output logic [31:0] step_y,
    input  logic        step_done,
    input  logic [31:0] step_return
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_LAUNCH,
        S_WAIT,
        S_UPDATE,
        S_DONE
    } state_t;

    localparam logic [15:0] ITER_CAP = 16'(MAX_ITER);

    state_t             state_q;
    logic signed [31:0] x_q;
    logic signed [31:0] a_q;
    logic        [31:0] u_q;
    logic        [31:0] y_q;
    logic        [31:0] dx_q;
    logic        [15:0] iter_q;
    logic        [31:0] p_q;
    logic        [31:0] q_q;
    logic        [31:0] r_q;
    logic        [31:0] ynx_q;
    logic               got_q;
    logic         [1:0] mstep_q;
    logic               step_start_q;
    logic               ap_done_q;
    logic        [31:0] x_out_q;
    logic        [31:0] u_out_q;
    logic        [31:0] y_out_q;
    logic        [15:0] iter_out_q;

    logic [31:0] x3;
    logic [31:0] dx3;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [31:0] prod;

    // Shared multiplier: operands selected by the sub-step counter.
    always_comb begin
        x3    = (x_q << 2) - x_q;
        dx3   = (dx_q << 2) - dx_q;
        mul_a = '0;
        mul_b = '0;
        case (mstep_q)
            2'd0: begin
                mul_a = u_q;
                mul_b = dx_q;
            end
            2'd1: begin
                mul_a = p_q;
                mul_b = x3;
            end
            2'd2: begin
                mul_a = y_q;
                mul_b = dx3;
            end
            default: begin
                mul_a = '0;
                mul_b = '0;
            end
        endcase
        prod = mul_a * mul_b;
    end

    // Control FSM plus datapath and output registers.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            a_q          <= '0;
            u_q          <= '0;
            y_q          <= '0;
            dx_q         <= '0;
            iter_q       <= '0;
            p_q          <= '0;
            q_q          <= '0;
            r_q          <= '0;
            ynx_q        <= '0;
            got_q        <= 1'b0;
            mstep_q      <= '0;
            step_start_q <= 1'b0;
            ap_done_q    <= 1'b0;
            x_out_q      <= '0;
            u_out_q      <= '0;
            y_out_q      <= '0;
            iter_out_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ap_start) begin
                        x_q     <= x0;
                        dx_q    <= dx;
                        u_q     <= u0;
                        y_q     <= y0;
                        a_q     <= a;
                        iter_q  <= '0;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!(x_q < a_q) || (iter_q == ITER_CAP)) begin
                        x_out_q    <= x_q;
                        u_out_q    <= u_q;
                        y_out_q    <= y_q;
                        iter_out_q <= iter_q;
                        ap_done_q  <= 1'b1;
                        state_q    <= S_DONE;
                    end else begin
                        step_start_q <= 1'b1;
                        state_q      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    step_start_q <= 1'b0;
                    mstep_q      <= '0;
                    got_q        <= 1'b0;
                    state_q      <= S_WAIT;
                end
                S_WAIT: begin
                    case (mstep_q)
                        2'd0:    p_q <= prod;
                        2'd1:    q_q <= prod;
                        2'd2:    r_q <= prod;
                        default: ;
                    endcase
                    if (mstep_q != 2'd3) begin
                        mstep_q <= mstep_q + 2'd1;
                    end
                    if (step_done) begin
                        ynx_q <= step_return;
                        got_q <= 1'b1;
                    end
                    // r lands on the same edge that leaves the third sub-step,
                    // so UPDATE may follow directly once y_next is in hand.
                    if ((step_done || got_q) && (mstep_q >= 2'd2)) begin
                        state_q <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    x_q     <= x_q + dx_q;
                    u_q     <= u_q - q_q - r_q;
                    y_q     <= ynx_q;
                    iter_q  <= iter_q + 16'd1;
                    state_q <= S_CHECK;
                end
                S_DONE: begin
                    ap_done_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ap_done    = ap_done_q;
    assign ap_ready   = ap_done_q;
    assign ap_idle    = (state_q == S_IDLE) && !ap_start;
    assign ap_return  = y_out_q;
    assign x_out      = x_out_q;
    assign u_out      = u_out_q;
    assign y_out      = y_out_q;
    assign iter_count = iter_out_q;
    assign step_start = step_start_q;
    assign step_x     = x_q;
    assign step_dx    = dx_q;
    assign step_u     = u_q;
    assign step_y     = y_q;

endmodule

// File: tb/tb_diffeq_driver.sv
// Directed testbench for diffeq_driver with a behavioural step core model.
module tb_diffeq_driver;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic [31:0] x0, dx, u0, y0, a;
    logic [31:0] ap_return, x_out, u_out, y_out;
    logic [15:0] iter_count;
    logic        step_start;
    logic [31:0] step_x, step_dx, step_u, step_y;
    logic        step_done;
    logic [31:0] step_return;

    int n_cmp  = 0;
    int n_fail = 0;

    // Step core model controls/state
    int done_lat = 4;
    int sd_cnt;

    // run_job results
    int done_cyc;
    int n_launch;
    int launch_cyc [0:7];
    logic rdy_at_done;

    diffeq_driver #(.MAX_ITER(4)) dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .ap_start    (ap_start),
        .ap_done     (ap_done),
        .ap_idle     (ap_idle),
        .ap_ready    (ap_ready),
        .x0          (x0),
        .dx          (dx),
        .u0          (u0),
        .y0          (y0),
        .a           (a),
        .ap_return   (ap_return),
        .x_out       (x_out),
        .u_out       (u_out),
        .y_out       (y_out),
        .iter_count  (iter_count),
        .step_start  (step_start),
        .step_x      (step_x),
        .step_dx     (step_dx),
        .step_u      (step_u),
        .step_y      (step_y),
        .step_done   (step_done),
        .step_return (step_return)
    );

    always #5 ap_clk = ~ap_clk;

    // Step core stand-in: y_next = y + u*dx - y*(3*dx), done after done_lat cycles.
    always @(posedge ap_clk) begin
        if (ap_rst) begin
            sd_cnt    <= 0;
            step_done <= 1'b0;
        end else begin
            step_done <= 1'b0;
            if (step_start) begin
                sd_cnt      <= 1;
                step_return <= step_y + step_u * step_dx - step_y * ((step_dx << 2) - step_dx);
                if (done_lat == 1) step_done <= 1'b1;
            end else if (sd_cnt != 0) begin
                if (sd_cnt < done_lat) begin
                    sd_cnt <= sd_cnt + 1;
                    if (sd_cnt + 1 == done_lat) step_done <= 1'b1;
                end else begin
                    sd_cnt <= 0;
                end
            end
        end
    end

    // Launch one run and record step_start pulses and the ap_done cycle.
    task automatic run_job(input logic [31:0] ix0, input logic [31:0] idx,
                           input logic [31:0] iu0, input logic [31:0] iy0,
                           input logic [31:0] ia);
        int cyc;
        @(negedge ap_clk);
        x0 = ix0; dx = idx; u0 = iu0; y0 = iy0; a = ia;
        ap_start = 1'b1;
        cyc = 0;
        done_cyc = -1;
        n_launch = 0;
        rdy_at_done = 1'b0;
        while (done_cyc < 0 && cyc < 200) begin
            @(negedge ap_clk);
            cyc++;
            ap_start = 1'b0;
            if (step_start) begin
                if (n_launch < 8) launch_cyc[n_launch] = cyc;
                n_launch++;
            end
            if (ap_done) begin
                done_cyc = cyc;
                rdy_at_done = ap_ready;
            end
        end
    endtask

    task automatic test_reset();
        ap_rst = 1'b1; ap_start = 1'b0;
        x0 = '0; dx = '0; u0 = '0; y0 = '0; a = '0;
        repeat (3) @(negedge ap_clk);
        n_cmp++; if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got=%b exp=1", ap_idle); end
        n_cmp++; if (ap_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", ap_done); end
        n_cmp++; if (ap_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", ap_ready); end
        n_cmp++; if (step_start !== 1'b0) begin n_fail++; $display("FAIL reset_step_start got=%b exp=0", step_start); end
        n_cmp++; if (ap_return !== 32'h0) begin n_fail++; $display("FAIL reset_return got=%h exp=0", ap_return); end
        n_cmp++; if (iter_count !== 16'h0) begin n_fail++; $display("FAIL reset_iter got=%h exp=0", iter_count); end
        n_cmp++; if (step_x !== 32'h0) begin n_fail++; $display("FAIL reset_step_x got=%h exp=0", step_x); end
        ap_rst = 1'b0;
    endtask

    task automatic test_single_iter();
        run_job(32'd0, 32'd1, 32'd2, 32'd3, 32'd1);
        n_cmp++; if (n_launch !== 1) begin n_fail++; $display("FAIL single_launches got=%0d exp=1", n_launch); end
        n_cmp++; if (launch_cyc[0] !== 2) begin n_fail++; $display("FAIL single_launch_cyc got=%0d exp=2", launch_cyc[0]); end
        n_cmp++; if (done_cyc !== 9) begin n_fail++; $display("FAIL single_done_cyc got=%0d exp=9", done_cyc); end
        n_cmp++; if (rdy_at_done !== 1'b1) begin n_fail++; $display("FAIL single_ready got=%b exp=1", rdy_at_done); end
        n_cmp++; if (x_out !== 32'd1) begin n_fail++; $display("FAIL single_x got=%h exp=1", x_out); end
        n_cmp++; if (u_out !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL single_u got=%h exp=fffffff9", u_out); end
        n_cmp++; if (y_out !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL single_y got=%h exp=fffffffc", y_out); end
        n_cmp++; if (ap_return !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL single_return got=%h exp=fffffffc", ap_return); end
        n_cmp++; if (iter_count !== 16'd1) begin n_fail++; $display("FAIL single_iter got=%0d exp=1", iter_count); end
        @(negedge ap_clk);
        n_cmp++; if (ap_done !== 1'b0) begin n_fail++; $display("FAIL single_done_width got=%b exp=0", ap_done); end
        n_cmp++; if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL single_idle_after got=%b exp=1", ap_idle); end
        n_cmp++; if (u_out !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL single_u_hold got=%h exp=fffffff9", u_out); end
    endtask

    task automatic test_zero_iter();
        run_job(32'd5, 32'd3, 32'hFFFF_FFF8, 32'd44, 32'd5);
        n_cmp++; if (n_launch !== 0) begin n_fail++; $display("FAIL zero_launches got=%0d exp=0", n_launch); end
        n_cmp++; if (done_cyc !== 2) begin n_fail++; $display("FAIL zero_done_cyc got=%0d exp=2", done_cyc); end
        n_cmp++; if (x_out !== 32'd5) begin n_fail++; $display("FAIL zero_x got=%h exp=5", x_out); end
        n_cmp++; if (u_out !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL zero_u got=%h exp=fffffff8", u_out); end
        n_cmp++; if (y_out !== 32'd44) begin n_fail++; $display("FAIL zero_y got=%h exp=2c", y_out); end
        n_cmp++; if (iter_count !== 16'd0) begin n_fail++; $display("FAIL zero_iter got=%0d exp=0", iter_count); end
    endtask

    task automatic test_iter_cap();
        run_job(32'd0, 32'd0, 32'd7, 32'd9, 32'd1);
        n_cmp++; if (n_launch !== 4) begin n_fail++; $display("FAIL cap_launches got=%0d exp=4", n_launch); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (launch_cyc[i] !== 2 + 7 * i) begin
                n_fail++; $display("FAIL cap_launch_cyc[%0d] got=%0d exp=%0d", i, launch_cyc[i], 2 + 7 * i);
            end
        end
        n_cmp++; if (done_cyc !== 30) begin n_fail++; $display("FAIL cap_done_cyc got=%0d exp=30", done_cyc); end
        n_cmp++; if (u_out !== 32'd7) begin n_fail++; $display("FAIL cap_u got=%h exp=7", u_out); end
        n_cmp++; if (y_out !== 32'd9) begin n_fail++; $display("FAIL cap_y got=%h exp=9", y_out); end
        n_cmp++; if (x_out !== 32'd0) begin n_fail++; $display("FAIL cap_x got=%h exp=0", x_out); end
        n_cmp++; if (iter_count !== 16'd4) begin n_fail++; $display("FAIL cap_iter got=%0d exp=4", iter_count); end
    endtask

    task automatic test_signed_bound();
        // u/y trace: (1,0) -> (10,1) -> (67,8) -> (244,51)
        run_job(32'hFFFF_FFFD, 32'd1, 32'd1, 32'd0, 32'd0);
        n_cmp++; if (n_launch !== 3) begin n_fail++; $display("FAIL signed_launches got=%0d exp=3", n_launch); end
        n_cmp++; if (done_cyc !== 23) begin n_fail++; $display("FAIL signed_done_cyc got=%0d exp=23", done_cyc); end
        n_cmp++; if (x_out !== 32'd0) begin n_fail++; $display("FAIL signed_x got=%h exp=0", x_out); end
        n_cmp++; if (u_out !== 32'd244) begin n_fail++; $display("FAIL signed_u got=%0d exp=244", u_out); end
        n_cmp++; if (y_out !== 32'd51) begin n_fail++; $display("FAIL signed_y got=%0d exp=51", y_out); end
        n_cmp++; if (iter_count !== 16'd3) begin n_fail++; $display("FAIL signed_iter got=%0d exp=3", iter_count); end
    endtask

    task automatic test_step_latency();
        done_lat = 2;
        run_job(32'd0, 32'd1, 32'd2, 32'd3, 32'd1);
        n_cmp++; if (u_out !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL early_u got=%h exp=fffffff9", u_out); end
        n_cmp++; if (y_out !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL early_y got=%h exp=fffffffc", y_out); end
        n_cmp++; if (iter_count !== 16'd1) begin n_fail++; $display("FAIL early_iter got=%0d exp=1", iter_count); end
        done_lat = 6;
        run_job(32'd0, 32'd1, 32'd2, 32'd3, 32'd1);
        n_cmp++; if (done_cyc !== 11) begin n_fail++; $display("FAIL late_done_cyc got=%0d exp=11", done_cyc); end
        n_cmp++; if (u_out !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL late_u got=%h exp=fffffff9", u_out); end
        n_cmp++; if (y_out !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL late_y got=%h exp=fffffffc", y_out); end
        done_lat = 4;
    endtask

    task automatic test_reset_mid_run();
        @(negedge ap_clk);
        x0 = 32'hFFFF_FFFD; dx = 32'd1; u0 = 32'd1; y0 = 32'd0; a = 32'd0;
        ap_start = 1'b1;
        @(negedge ap_clk);   // cycle 1: CHECK
        ap_start = 1'b0;
        @(negedge ap_clk);   // cycle 2: LAUNCH
        @(negedge ap_clk);   // cycle 3: WAIT
        @(negedge ap_clk);   // cycle 4: WAIT
        ap_rst = 1'b1;
        @(negedge ap_clk);
        n_cmp++; if (step_start !== 1'b0) begin n_fail++; $display("FAIL midrst_step_start got=%b exp=0", step_start); end
        n_cmp++; if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL midrst_idle got=%b exp=1", ap_idle); end
        n_cmp++; if (ap_done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got=%b exp=0", ap_done); end
        n_cmp++; if (x_out !== 32'd0) begin n_fail++; $display("FAIL midrst_x got=%h exp=0", x_out); end
        n_cmp++; if (step_x !== 32'd0) begin n_fail++; $display("FAIL midrst_step_x got=%h exp=0", step_x); end
        ap_rst = 1'b0;
        run_job(32'd0, 32'd1, 32'd2, 32'd3, 32'd1);
        n_cmp++; if (done_cyc !== 9) begin n_fail++; $display("FAIL midrst_rerun_cyc got=%0d exp=9", done_cyc); end
        n_cmp++; if (u_out !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL midrst_rerun_u got=%h exp=fffffff9", u_out); end
        n_cmp++; if (ap_return !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL midrst_rerun_ret got=%h exp=fffffffc", ap_return); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int n_done;
        int first_done;
        int second_done;
        @(negedge ap_clk);
        x0 = 32'd0; dx = 32'd1; u0 = 32'd2; y0 = 32'd3; a = 32'd1;
        ap_start = 1'b1;
        cyc = 0; n_done = 0; first_done = -1; second_done = -1;
        while (cyc < 14) begin
            @(negedge ap_clk);
            cyc++;
            if (ap_done) begin
                n_done++;
                if (first_done < 0) begin
                    first_done = cyc;
                    n_cmp++; if (u_out !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL b2b_u1 got=%h exp=fffffff9", u_out); end
                    x0 = 32'd5; dx = 32'd7; u0 = 32'd11; y0 = 32'd12; a = 32'd5;
                end else if (second_done < 0) begin
                    second_done = cyc;
                    n_cmp++; if (x_out !== 32'd5) begin n_fail++; $display("FAIL b2b_x2 got=%h exp=5", x_out); end
                    n_cmp++; if (u_out !== 32'd11) begin n_fail++; $display("FAIL b2b_u2 got=%h exp=b", u_out); end
                    n_cmp++; if (y_out !== 32'd12) begin n_fail++; $display("FAIL b2b_y2 got=%h exp=c", y_out); end
                    n_cmp++; if (iter_count !== 16'd0) begin n_fail++; $display("FAIL b2b_iter2 got=%0d exp=0", iter_count); end
                    ap_start = 1'b0;
                end
            end
            if (cyc == 10) begin
                n_cmp++; if (ap_idle !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_busy got=%b exp=0", ap_idle); end
            end
        end
        n_cmp++; if (first_done !== 9) begin n_fail++; $display("FAIL b2b_done1_cyc got=%0d exp=9", first_done); end
        n_cmp++; if (second_done !== 12) begin n_fail++; $display("FAIL b2b_done2_cyc got=%0d exp=12", second_done); end
        n_cmp++; if (n_done !== 2) begin n_fail++; $display("FAIL b2b_done_count got=%0d exp=2", n_done); end
        ap_start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_iter();
        test_zero_iter();
        test_iter_cap();
        test_signed_bound();
        test_step_latency();
        test_reset_mid_run();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
